// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - periodic multi-channel CAN frame scheduler with priority arbitration and retry
module can_tx_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int TICK_CYCLES = 50_000,
    parameter int PERIOD_W    = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*11-1:0]     ch_id,
    input  logic [NUM_CH*4-1:0]      ch_dlc,
    input  logic [NUM_CH*PERIOD_W-1:0] ch_period,
    input  logic [NUM_CH*64-1:0]     ch_data,
    input  logic                     status_warning,
    input  logic                     status_bus_off,
    output logic [63:0]              stm_send_data_out_tdata,
    output logic [10:0]              stm_send_data_out_tid,
    output logic [7:0]               stm_send_data_out_tkeep,
    output logic                     stm_send_data_out_tvalid,
    input  logic                     stm_send_data_out_tready,
    input  logic [2:0]               stm_result_in_tdata,
    input  logic                     stm_result_in_tvalid,
    output logic                     stm_result_in_tready,
    output logic [NUM_CH-1:0]        ch_overrun,
    output logic [NUM_CH-1:0]        ch_drop,
    input  logic                     clear_status,
    output logic                     warning_seen,
    output logic [15:0]              frames_sent
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RES} state_t;

    state_t r_state, w_state_nxt;

    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;
    logic [PERIOD_W-1:0] r_period_cnt [NUM_CH];
    logic [PERIOD_W-1:0] w_cur_cnt    [NUM_CH];
    logic [NUM_CH-1:0]   r_armed;
    logic [NUM_CH-1:0]   w_active;
    logic [NUM_CH-1:0]   w_expire;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_overrun;
    logic [NUM_CH-1:0]   r_drop;
    logic                r_warning_seen;

    logic                w_found;
    logic [IDX_W-1:0]    w_sel;
    logic [10:0]         w_sel_id;
    logic [3:0]          w_sel_dlc;
    logic [63:0]         w_sel_data;

    logic                w_grant;
    logic                w_success;
    logic                w_retry_inc;
    logic                w_drop_ev;
    logic [NUM_CH-1:0]   w_grant_mask;
    logic [NUM_CH-1:0]   w_drop_mask;

    logic [63:0]         r_tdata;
    logic [10:0]         r_tid;
    logic [7:0]          r_tkeep;
    logic [IDX_W-1:0]    r_cur_ch;
    logic [RTY_W-1:0]    r_retry;
    logic [15:0]         r_frames_sent;

    function automatic logic [7:0] dlc_keep(input logic [3:0] dlc);
        if (dlc >= 4'd8)
            return 8'hFF;
        else
            return (8'd1 << dlc[2:0]) - 8'd1;
    endfunction

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // An unarmed channel behaves as if its counter already held ch_period.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_active[k]  = ch_enable[k] && (ch_period[k*PERIOD_W +: PERIOD_W] != '0);
            w_cur_cnt[k] = r_armed[k] ? r_period_cnt[k] : ch_period[k*PERIOD_W +: PERIOD_W];
            w_expire[k]  = w_active[k] && w_tick && (w_cur_cnt[k] == PERIOD_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= '0;
            for (int k = 0; k < NUM_CH; k++)
                r_period_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_active[k]) begin
                    r_armed[k]      <= 1'b0;
                    r_period_cnt[k] <= ch_period[k*PERIOD_W +: PERIOD_W];
                end else begin
                    r_armed[k] <= 1'b1;
                    if (!w_tick)
                        r_period_cnt[k] <= w_cur_cnt[k];
                    else if (w_expire[k])
                        r_period_cnt[k] <= ch_period[k*PERIOD_W +: PERIOD_W];
                    else
                        r_period_cnt[k] <= w_cur_cnt[k] - 1'b1;
                end
            end
        end
    end

    // Strict less-than keeps the lowest index on equal IDs.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_id   = '1;
        w_sel_dlc  = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_pending[k] && (!w_found || (ch_id[k*11 +: 11] < w_sel_id))) begin
                w_found    = 1'b1;
                w_sel      = IDX_W'(k);
                w_sel_id   = ch_id[k*11 +: 11];
                w_sel_dlc  = ch_dlc[k*4 +: 4];
                w_sel_data = ch_data[k*64 +: 64];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_success   = 1'b0;
        w_retry_inc = 1'b0;
        w_drop_ev   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!status_bus_off && w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (stm_send_data_out_tready)
                    w_state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (stm_result_in_tvalid) begin
                    if (stm_result_in_tdata == 3'd0) begin
                        w_success   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_retry < RTY_W'(MAX_RETRY)) begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_drop_ev   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_grant_mask = w_grant   ? (NUM_CH'(1) << w_sel)    : '0;
    assign w_drop_mask  = w_drop_ev ? (NUM_CH'(1) << r_cur_ch) : '0;

    // Expiry on the grant cycle re-arms pending for the next frame, not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_overrun      <= '0;
            r_drop         <= '0;
            r_warning_seen <= 1'b0;
        end else begin
            r_pending      <= (r_pending & w_active & ~w_grant_mask) | w_expire;
            r_overrun      <= (w_expire & r_pending & ~w_grant_mask) | (clear_status ? '0 : r_overrun);
            r_drop         <= w_drop_mask | (clear_status ? '0 : r_drop);
            r_warning_seen <= status_warning | (clear_status ? 1'b0 : r_warning_seen);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata       <= '0;
            r_tid         <= '0;
            r_tkeep       <= '0;
            r_cur_ch      <= '0;
            r_retry       <= '0;
            r_frames_sent <= '0;
        end else begin
            if (w_grant) begin
                r_tdata  <= w_sel_data;
                r_tid    <= w_sel_id;
                r_tkeep  <= dlc_keep(w_sel_dlc);
                r_cur_ch <= w_sel;
                r_retry  <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_success)
                r_frames_sent <= r_frames_sent + 16'd1;
        end
    end

    assign stm_send_data_out_tdata  = r_tdata;
    assign stm_send_data_out_tid    = r_tid;
    assign stm_send_data_out_tkeep  = r_tkeep;
    assign stm_send_data_out_tvalid = (r_state == S_SEND);
    assign stm_result_in_tready     = (r_state == S_WAIT_RES);
    assign ch_overrun               = r_overrun;
    assign ch_drop                  = r_drop;
    assign warning_seen             = r_warning_seen;
    assign frames_sent              = r_frames_sent;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - directed self-checking bench for can_tx_scheduler
module tb_can_tx_scheduler;

    localparam int NUM_CH = 4;
    localparam int TICK   = 10;
    localparam int PW     = 16;
    localparam int MR     = 3;

    localparam logic [63:0] D0 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D1 = 64'hA5A5_0F0F_F0F0_5A5A;
    localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_CH-1:0]      ch_enable;
    logic [NUM_CH*11-1:0]   ch_id;
    logic [NUM_CH*4-1:0]    ch_dlc;
    logic [NUM_CH*PW-1:0]   ch_period;
    logic [NUM_CH*64-1:0]   ch_data;
    logic                   status_warning;
    logic                   status_bus_off;
    logic [63:0]            tdata;
    logic [10:0]            tid;
    logic [7:0]             tkeep;
    logic                   tvalid;
    logic                   tready;
    logic [2:0]             res_tdata;
    logic                   res_tvalid;
    logic                   res_tready;
    logic [NUM_CH-1:0]      ch_overrun;
    logic [NUM_CH-1:0]      ch_drop;
    logic                   clear_status;
    logic                   warning_seen;
    logic [15:0]            frames_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    can_tx_scheduler #(
        .NUM_CH(NUM_CH), .TICK_CYCLES(TICK), .PERIOD_W(PW), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_enable(ch_enable), .ch_id(ch_id), .ch_dlc(ch_dlc),
        .ch_period(ch_period), .ch_data(ch_data),
        .status_warning(status_warning), .status_bus_off(status_bus_off),
        .stm_send_data_out_tdata(tdata), .stm_send_data_out_tid(tid),
        .stm_send_data_out_tkeep(tkeep), .stm_send_data_out_tvalid(tvalid),
        .stm_send_data_out_tready(tready),
        .stm_result_in_tdata(res_tdata), .stm_result_in_tvalid(res_tvalid),
        .stm_result_in_tready(res_tready),
        .ch_overrun(ch_overrun), .ch_drop(ch_drop),
        .clear_status(clear_status), .warning_seen(warning_seen),
        .frames_sent(frames_sent)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [10:0] id, input logic [3:0] dlc,
                          input logic [15:0] per, input logic [63:0] data);
        ch_id[k*11 +: 11]  = id;
        ch_dlc[k*4 +: 4]   = dlc;
        ch_period[k*PW +: PW] = per;
        ch_data[k*64 +: 64] = data;
        ch_enable[k]       = 1'b1;
    endtask

    task automatic start_test();
        @(negedge clk);
        rst            = 1'b1;
        ch_enable      = '0;
        ch_id          = '0;
        ch_dlc         = '0;
        ch_period      = '0;
        ch_data        = '0;
        status_warning = 1'b0;
        status_bus_off = 1'b0;
        tready         = 1'b0;
        res_tdata      = 3'd0;
        res_tvalid     = 1'b0;
        clear_status   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!tvalid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!tvalid)
            check({tag, " timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_frame(input string tag, input logic [10:0] id, input logic [7:0] keep,
                            input logic [63:0] data, input logic [2:0] res);
        int n;
        wait_valid(tag, 60, n);
        check({tag, " tid"}, 64'(tid), 64'(id));
        check({tag, " tkeep"}, 64'(tkeep), 64'(keep));
        check({tag, " tdata"}, tdata, data);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        check({tag, " res_tready"}, 64'(res_tready), 64'd1);
        res_tdata  = res;
        res_tvalid = 1'b1;
        @(negedge clk);
        res_tvalid = 1'b0;
        res_tdata  = 3'd0;
    endtask

    initial begin
        int n;
        int t0;
        bit seen;

        start_test();
        check("rst tvalid", 64'(tvalid), 64'd0);
        check("rst res_tready", 64'(res_tready), 64'd0);
        check("rst tid", 64'(tid), 64'd0);
        check("rst tdata", tdata, 64'd0);
        check("rst frames", 64'(frames_sent), 64'd0);
        check("rst flags", 64'({ch_overrun, ch_drop, warning_seen}), 64'd0);

        // Single periodic channel with success results
        set_ch(0, 11'h3D9, 4'd2, 16'd3, D0);
        rst = 1'b0;
        status_warning = 1'b1;
        wait_valid("t1 first", 40, n);
        check("t1 latency 30..32", 64'(n >= 30 && n <= 32), 64'd1);
        status_warning = 1'b0;
        check("t1 warning_seen", 64'(warning_seen), 64'd1);
        t0 = cyc;
        do_frame("t1 f1", 11'h3D9, 8'h03, D0, 3'd0);
        check("t1 frames 1", 64'(frames_sent), 64'd1);
        wait_valid("t1 second", 40, n);
        check("t1 period", 64'(cyc - t0), 64'd30);
        do_frame("t1 f2", 11'h3D9, 8'h03, D0, 3'd0);
        check("t1 frames 2", 64'(frames_sent), 64'd2);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        check("t1 warning cleared", 64'(warning_seen), 64'd0);

        // Priority: lower ID wins over lower index
        start_test();
        set_ch(0, 11'h3E9, 4'd8, 16'd3, D0);
        set_ch(1, 11'h3D9, 4'd8, 16'd3, D1);
        rst = 1'b0;
        do_frame("t2 first", 11'h3D9, 8'hFF, D1, 3'd0);
        do_frame("t2 second", 11'h3E9, 8'hFF, D0, 3'd0);
        check("t2 frames", 64'(frames_sent), 64'd2);

        // DLC clamp and zero
        start_test();
        set_ch(2, 11'h100, 4'd12, 16'd2, D2);
        set_ch(3, 11'h200, 4'd0, 16'd2, D3);
        rst = 1'b0;
        do_frame("t3 dlc12", 11'h100, 8'hFF, D2, 3'd0);
        do_frame("t3 dlc0", 11'h200, 8'h00, D3, 3'd0);

        // Retries with failing results, payload snapshot held across retries
        start_test();
        set_ch(0, 11'h123, 4'd4, 16'd3, D0);
        rst = 1'b0;
        do_frame("t4 try0", 11'h123, 8'h0F, D0, 3'd1);
        ch_data[63:0] = D3;
        ch_id[10:0]   = 11'h7FF;
        do_frame("t4 try1", 11'h123, 8'h0F, D0, 3'd1);
        do_frame("t4 try2", 11'h123, 8'h0F, D0, 3'd5);
        do_frame("t4 try3", 11'h123, 8'h0F, D0, 3'd1);
        check("t4 drop", 64'(ch_drop), 64'b0001);
        check("t4 frames", 64'(frames_sent), 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= tvalid;
        end
        check("t4 no 5th attempt", 64'(seen), 64'd0);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        check("t4 drop cleared", 64'(ch_drop), 64'd0);

        // Overrun while controller stalls; only one extra frame afterwards
        start_test();
        set_ch(0, 11'h055, 4'd1, 16'd3, D1);
        rst = 1'b0;
        wait_valid("t5 first", 40, n);
        repeat (70) @(negedge clk);
        check("t5 tvalid held", 64'(tvalid), 64'd1);
        check("t5 tid stable", 64'(tid), 64'h055);
        check("t5 overrun", 64'(ch_overrun), 64'b0001);
        do_frame("t5 f1", 11'h055, 8'h01, D1, 3'd0);
        do_frame("t5 extra", 11'h055, 8'h01, D1, 3'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= tvalid;
        end
        check("t5 no queue", 64'(seen), 64'd0);
        check("t5 frames", 64'(frames_sent), 64'd2);

        // Bus-off blocks grants, pending retained; then reset mid-SEND
        start_test();
        set_ch(0, 11'h321, 4'd8, 16'd1, D2);
        status_bus_off = 1'b1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= tvalid;
        end
        check("t6 bus_off no tvalid", 64'(seen), 64'd0);
        check("t6 bus_off overrun", 64'(ch_overrun), 64'b0001);
        status_bus_off = 1'b0;
        wait_valid("t6 resume", 3, n);
        check("t6 resume fast", 64'(n >= 1 && n <= 2), 64'd1);
        check("t6 tid", 64'(tid), 64'h321);
        rst = 1'b1;
        #1;
        check("t6 rst tvalid", 64'(tvalid), 64'd0);
        check("t6 rst outputs", 64'({tid, tkeep, res_tready}), 64'd0);
        check("t6 rst tdata", tdata, 64'd0);
        check("t6 rst flags", 64'({ch_overrun, ch_drop, frames_sent}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
